// File: rtl/mr_bus_arb.sv
// Two-master Wishbone-style pipelined bus arbiter with an outstanding-request tracker.
// Define MR_BUS_ARB_RR_EN to switch simultaneous-request grants from fixed priority (master 1) to round-robin.
module mr_bus_arb #(
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int OUTST_W = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    output logic [DW-1:0]     m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic              m0_stall_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    output logic [DW-1:0]     m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic              m1_stall_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    output logic [DW/8-1:0]   s_sel_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    input  logic              s_stall_i,

    output logic [1:0]        gnt_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [OUTST_W-1:0]   cnt_q, cnt_d;
    logic                 inc, dec;

`ifdef MR_BUS_ARB_RR_EN
    // 1 = master 1 held the bus most recently
    logic                 last_q, last_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
`ifdef MR_BUS_ARB_RR_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef MR_BUS_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef MR_BUS_ARB_RR_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
`ifdef MR_BUS_ARB_RR_EN
                    state_d = last_q ? OWN0 : OWN1;
`else
                    state_d = OWN1;
`endif
                end else if (m1_cyc_i) begin
                    state_d = OWN1;
                end else if (m0_cyc_i) begin
                    state_d = OWN0;
                end
            end
            OWN0: if (!m0_cyc_i || s_err_i) state_d = IDLE;
            OWN1: if (!m1_cyc_i || s_err_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef MR_BUS_ARB_RR_EN
        if (state_q == IDLE && state_d == OWN1) last_d = 1'b1;
        if (state_q == IDLE && state_d == OWN0) last_d = 1'b0;
`endif
    end

    always_comb begin
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_adr_o    = '0;
        s_dat_o    = '0;
        s_sel_o    = '0;
        gnt_o      = 2'b00;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m0_stall_o = 1'b1;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        m1_stall_o = 1'b1;
        unique case (state_q)
            OWN0: begin
                gnt_o      = 2'b01;
                s_cyc_o    = m0_cyc_i;
                s_stb_o    = m0_cyc_i & m0_stb_i;
                s_we_o     = m0_we_i;
                s_adr_o    = m0_adr_i;
                s_dat_o    = m0_dat_i;
                s_sel_o    = m0_sel_i;
                m0_ack_o   = s_ack_i;
                m0_err_o   = s_err_i;
                m0_stall_o = s_stall_i;
            end
            OWN1: begin
                gnt_o      = 2'b10;
                s_cyc_o    = m1_cyc_i;
                s_stb_o    = m1_cyc_i & m1_stb_i;
                s_we_o     = m1_we_i;
                s_adr_o    = m1_adr_i;
                s_dat_o    = m1_dat_i;
                s_sel_o    = m1_sel_i;
                m1_ack_o   = s_ack_i;
                m1_err_o   = s_err_i;
                m1_stall_o = s_stall_i;
            end
            default: ;
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // A response arriving with nothing outstanding is ignored rather than wrapping the count.
    assign inc = s_stb_o & ~s_stall_i;
    assign dec = (s_ack_i | s_err_i) & (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (state_d == IDLE) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            if (cnt_q != '1) cnt_d = cnt_q + OUTST_W'(1);
        end else if (dec && !inc) begin
            cnt_d = cnt_q - OUTST_W'(1);
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: doc/mr_bus_arb.md
MR_BUS_ARB -- requirements
Module: mr_bus_arb

Interface
REQ-001 SHALL have parameter AW, default 30, the word-address width.
REQ-002 SHALL have parameter DW, default 32, the data width (equal to `XLEN).
REQ-003 SHALL have parameter OUTST_W, default 3, the width of the outstanding-request counter.
REQ-004 SHALL have the ports below; reset rst is synchronous, active-high; clock clk.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (instruction fetch) bus controls.
REQ-008 m0_adr_i  in  AW;  m0_dat_i  in  DW;  m0_sel_i  in  DW/8  master 0 request fields.
REQ-009 m0_dat_o  out  DW;  m0_ack_o, m0_err_o, m0_stall_o  out  1 each  master 0 responses.
REQ-010 m1_* ports SHALL be identical to the m0_* ports, for master 1 (load/store).
REQ-011 s_cyc_o, s_stb_o, s_we_o  out  1;  s_adr_o  out  AW;  s_dat_o  out  DW;  s_sel_o  out  DW/8  slave request.
REQ-012 s_dat_i  in  DW;  s_ack_i, s_err_i, s_stall_i  in  1  slave responses.
REQ-013 gnt_o  out  2  one-hot current grant (00 = idle);  busy_o  out  1  outstanding count nonzero.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, OWN0 and OWN1, held in a registered state.
REQ-015 In IDLE with only mN_cyc_i high, the FSM SHALL go to OWNn on the next edge.
REQ-016 In IDLE with both cyc inputs high, the FSM SHALL grant master 1 (fixed priority) unless REQ-033 applies.
REQ-017 In OWNn, the FSM SHALL return to IDLE on the first edge where mN_cyc_i is low, or on an edge where s_err_i is high.
REQ-018 No OWNn-to-OWNm transition SHALL occur without one IDLE cycle between them.
REQ-019 Slave request outputs SHALL be a combinational mux of the granted master's inputs.
REQ-020 In IDLE, s_cyc_o and s_stb_o SHALL be 0.
REQ-021 s_cyc_o SHALL equal the granted master's cyc, and s_stb_o SHALL equal the granted master's cyc AND stb.
REQ-022 A non-granted master SHALL see stall_o=1, ack_o=0 and err_o=0.
REQ-023 The granted master SHALL see the slave's stall, ack and err directly, with zero added latency.
REQ-024 mN_dat_o SHALL equal s_dat_i for both masters at all times.
REQ-025 The outstanding counter SHALL increment on an accepted strobe (s_stb_o & !s_stall_i).
REQ-026 The outstanding counter SHALL decrement on s_ack_i or s_err_i.
REQ-027 When increment and decrement occur in the same cycle, the outstanding counter SHALL be unchanged.
REQ-028 The outstanding counter SHALL saturate at 0 and at 2^OUTST_W-1; an ack at zero SHALL be ignored.
REQ-029 The outstanding counter SHALL clear when the FSM enters IDLE.
REQ-030 busy_o SHALL be 1 exactly when the outstanding counter is nonzero.
REQ-031 Grant latency SHALL be exactly one cycle: cyc rises at edge k, and s_cyc_o is 1 from cycle k+1.

Reset
REQ-032 While rst is sampled high, the state SHALL be IDLE and the counter 0; after that edge, gnt_o=00, busy_o=0, s_cyc_o=0 and s_stb_o=0, including when rst arrives mid-transfer.

Configuration
REQ-033 With MR_BUS_ARB_RR_EN defined, a last-grant flop SHALL be kept, and simultaneous IDLE requests SHALL grant the master not granted last; the flop SHALL reset to "master 0 last", so master 1 wins first.
REQ-034 Without MR_BUS_ARB_RR_EN, fixed priority to master 1 SHALL apply and no last-grant flop SHALL exist.

Verification
REQ-035 m0_cyc=1, stb=1, adr=0x10 at cycle 0 -> gnt_o=01 and s_adr_o=0x10 at cycle 1; ack at cycle 2 -> m0_ack_o=1, busy_o returns to 0.
REQ-036 Both cyc rise at cycle 0 (RR off) -> gnt_o=10 at cycle 1, m0_stall_o=1 throughout; m1 drops cyc -> IDLE one cycle, then gnt_o=01.
REQ-037 RR on, both masters hold cyc across three back-to-back transactions -> grant sequence 10, 01, 10, each separated by one IDLE cycle.
REQ-038 Master 1 issues 3 pipelined strobes with stall on the 2nd -> counter reads 1,1,2,... and reaches 0 after the 3rd ack; ack+stb in the same cycle keeps the count.
REQ-039 s_err_i during OWN0 -> m0_err_o=1 in the same cycle, IDLE and gnt_o=00 on the next cycle.
REQ-040 rst pulsed during OWN1 with 2 outstanding -> next cycle gnt_o=00, busy_o=0, s_cyc_o=0.
